fetch_ctrl: RTL

- Instruction-fetch sequencer that drives the decode stage.
- Holds the PC and issues one instruction-memory request at a time under a req/gnt/rvalid handshake.
- Buffers the returned word and presents it to the decoder with a one-cycle load_instr pulse once decode can accept it.
- Handles stalls and branch redirects; wrong-path responses are discarded.

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/fetch_pc_gen.sv | 29 ++
 rtl/fetch_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared front-end definitions: fetch FSM states, next-PC selectors,
// reset address and the base opcodes the decoder also uses.
package riscv_pkg;

  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_BRANCH = 2'd2
  } pc_sel_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selection for the fetch sequencer: hold, advance past the
// granted request, or take a word-aligned redirect target.
module fetch_pc_gen
  import riscv_pkg::*;
#(
  parameter int A_WIDTH = 32
) (
  input  logic [1:0]         pc_sel_i,
  input  logic [A_WIDTH-1:0] pc_i,
  input  logic [A_WIDTH-1:0] pc_req_i,
  input  logic [A_WIDTH-1:0] target_i,
  output logic [A_WIDTH-1:0] pc_next_o
);

  localparam logic [A_WIDTH-1:0] STEP       = A_WIDTH'(INSTR_BYTES);
  localparam logic [A_WIDTH-1:0] ALIGN_MASK = ~(A_WIDTH'(INSTR_BYTES - 1));

  // Sequential advance is from the PC of the fetched word, wrapping naturally.
  always_comb begin
    pc_next_o = pc_i;
    case (pc_sel_t'(pc_sel_i))
      PC_HOLD:   pc_next_o = pc_i;
      PC_INC:    pc_next_o = pc_req_i + STEP;
      PC_BRANCH: pc_next_o = target_i & ALIGN_MASK;
      default:   pc_next_o = pc_i;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding imem request, single-word
// buffer toward decode, branch redirects with wrong-path response dropping.
module fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int                 I_WIDTH  = 32,
  parameter int                 A_WIDTH  = 32,
  parameter logic [A_WIDTH-1:0] RESET_PC = A_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [A_WIDTH-1:0] imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [I_WIDTH-1:0] imem_rdata,
  input  logic               dec_ready,
  input  logic               stall,
  input  logic               branch_valid,
  input  logic [A_WIDTH-1:0] branch_target,
  output logic               load_instr,
  output logic [I_WIDTH-1:0] instr_out,
  output logic [A_WIDTH-1:0] pc_out,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  // Handshakes: a request transfers in the cycle imem_req && imem_gnt; a
  // response is taken only in WAIT when imem_rvalid=1; decode takes a word
  // in the cycle load_instr=1, which requires dec_ready=1 and stall=0.

  fetch_state_t       state_q, state_d;
  logic [A_WIDTH-1:0] pc_q, pc_d;
  logic [A_WIDTH-1:0] pc_req_q;
  logic [A_WIDTH-1:0] pc_buf_q;
  logic [I_WIDTH-1:0] instr_buf_q;
  logic               drop_q, drop_d;
  logic               latch_req;
  logic               capture;
  pc_sel_t            pc_sel;

  fetch_pc_gen #(
    .A_WIDTH (A_WIDTH)
  ) u_pc_gen (
    .pc_sel_i  (pc_sel),
    .pc_i      (pc_q),
    .pc_req_i  (pc_req_q),
    .target_i  (branch_target),
    .pc_next_o (pc_d)
  );

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    pc_sel     = PC_HOLD;
    latch_req  = 1'b0;
    capture    = 1'b0;
    imem_req   = 1'b0;
    busy       = 1'b0;
    load_instr = 1'b0;
    case (state_q)
      IDLE: begin
        if (branch_valid) pc_sel = PC_BRANCH;
        state_d = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          latch_req = 1'b1;
          state_d   = WAIT;
        end
        // A grant racing a redirect is for the old path: mark it for drop.
        if (branch_valid) begin
          pc_sel = PC_BRANCH;
          if (imem_gnt) drop_d = 1'b1;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (branch_valid) begin
          pc_sel = PC_BRANCH;
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            capture = 1'b1;
            pc_sel  = PC_INC;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (branch_valid) begin
          pc_sel  = PC_BRANCH;
          state_d = REQ;
        end else if (dec_ready && !stall) begin
          load_instr = 1'b1;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      pc_req_q    <= '0;
      drop_q      <= 1'b0;
      instr_buf_q <= '0;
      pc_buf_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      if (latch_req) pc_req_q <= pc_q;
      if (capture) begin
        instr_buf_q <= imem_rdata;
        pc_buf_q    <= pc_req_q;
      end
    end
  end

  // The buffer registers drive decode directly, so they only change on capture.
  assign instr_out = instr_buf_q;
  assign pc_out    = pc_buf_q;
  assign imem_addr = (state_q == REQ) ? pc_q : '0;
  assign dbg_state = state_q;

endmodule
